ram_b_lsu: RTL and testbench

- Load/store unit directly upstream of RAM_B, the 64 x 32-bit single-port block RAM.
- Drives the RAM port (clka, wea, addra, dina) and consumes douta.
- Turns byte-addressed byte, halfword and word requests from the datapath into RAM_B word accesses.
- Sub-word stores use read-modify-write because RAM_B has a single-bit wea; loads are sign- or zero-extended.

---
 rtl/ram_b_lsu.sv | 208 ++++++++++++++++++++
 tb/tb_ram_b_lsu.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_b_lsu.sv
// Load/store unit in front of RAM_B (single-port 32-bit block RAM).
// Byte/half/word requests become word accesses; sub-word stores use read-modify-write.
module ram_b_lsu #(
   parameter int ADDR_W  = 6,
   parameter int RAM_LAT = 1
) (
   input  logic              clka,
   input  logic              rsta_n,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [ADDR_W+1:0] addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       rdata,
   output logic              ram_wea,
   output logic [ADDR_W-1:0] ram_addra,
   output logic [31:0]       ram_dina,
   input  logic [31:0]       ram_douta
);

   typedef enum logic [2:0] {IDLE, RD_WAIT, WR, RMW_WAIT, RMW_WR, FIN} state_t;

   localparam logic [1:0] LAST_CNT = 2'(RAM_LAT);

   // Pick the addressed lane out of a RAM word and widen it to 32 bits.
   function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] sz,
                                                input logic [1:0] lane, input logic sx);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (sz)
         2'b00:   r = {{24{sx & b[7]}}, b};
         2'b01:   r = {{16{sx & h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [1:0] lane, input logic [15:0] data);
      logic [31:0] r;
      r = word;
      if (sz == 2'b00) begin
         case (lane)
            2'd0:    r[7:0]   = data[7:0];
            2'd1:    r[15:8]  = data[7:0];
            2'd2:    r[23:16] = data[7:0];
            default: r[31:24] = data[7:0];
         endcase
      end else if (lane[1]) begin
         r[31:16] = data;
      end else begin
         r[15:0] = data;
      end
      return r;
   endfunction

   state_t              state_q, state_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [1:0]          size_q, size_d;
   logic                sext_q, sext_d;
   logic [1:0]          lane_q, lane_d;
   logic [15:0]         wdat_q, wdat_d;
   logic                err_pend_q, err_pend_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                wea_q, wea_d;
   logic [ADDR_W-1:0]   addra_q, addra_d;
   logic [31:0]         dina_q, dina_d;
   logic                legal_s;

   // Alignment and size legality of the incoming request.
   always_comb begin
      case (size)
         2'b00:   legal_s = 1'b1;
         2'b01:   legal_s = ~addr[0];
         2'b10:   legal_s = (addr[1:0] == 2'b00);
         default: legal_s = 1'b0;
      endcase
   end

   // Next-state and next-output computation.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      size_d     = size_q;
      sext_d     = sext_q;
      lane_d     = lane_q;
      wdat_d     = wdat_q;
      err_pend_d = err_pend_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      rdata_d    = rdata_q;
      wea_d      = 1'b0;
      addra_d    = addra_q;
      dina_d     = dina_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               addra_d    = addr[ADDR_W+1:2];
               size_d     = size;
               sext_d     = sign_ext;
               lane_d     = addr[1:0];
               wdat_d     = wdata[15:0];
               cnt_d      = 2'd0;
               err_pend_d = ~legal_s;
               if (!legal_s) begin
                  state_d = FIN;
               end else if (we && (size == 2'b10)) begin
                  state_d = WR;
                  wea_d   = 1'b1;
                  dina_d  = wdata;
               end else if (we) begin
                  state_d = RMW_WAIT;
               end else begin
                  state_d = RD_WAIT;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RD_WAIT: begin
            if (cnt_q == LAST_CNT) begin
               rdata_d = load_extract(ram_douta, size_q, lane_q, sext_q);
               state_d = FIN;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         WR:      state_d = FIN;
         RMW_WAIT: begin
            if (cnt_q == LAST_CNT) begin
               dina_d  = store_merge(ram_douta, size_q, lane_q, wdat_q);
               wea_d   = 1'b1;
               state_d = RMW_WR;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         RMW_WR:  state_d = FIN;
         FIN: begin
            // done/err are registered, so they show in the cycle after FIN.
            done_d  = 1'b1;
            err_d   = err_pend_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         state_q    <= IDLE;
         cnt_q      <= 2'd0;
         size_q     <= 2'b00;
         sext_q     <= 1'b0;
         lane_q     <= 2'b00;
         wdat_q     <= 16'h0000;
         err_pend_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= 32'h0000_0000;
         wea_q      <= 1'b0;
         addra_q    <= '0;
         dina_q     <= 32'h0000_0000;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         size_q     <= size_d;
         sext_q     <= sext_d;
         lane_q     <= lane_d;
         wdat_q     <= wdat_d;
         err_pend_q <= err_pend_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
         wea_q      <= wea_d;
         addra_q    <= addra_d;
         dina_q     <= dina_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign rdata     = rdata_q;
   assign ram_wea   = wea_q;
   assign ram_addra = addra_q;
   assign ram_dina  = dina_q;

endmodule

// File: tb/tb_ram_b_lsu.sv
// Bench for ram_b_lsu: two instances (RAM_LAT=1 and 2), each with its own RAM_B model,
// table vectors, reset/busy corner sequences and random ops against an arithmetic model.
module tb_ram_b_lsu;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rsta_n;
   logic        req[2], we[2], sext[2], busy[2], done[2], err[2], wea[2];
   logic [1:0]  size[2];
   logic [7:0]  addr[2];
   logic [5:0]  addra[2];
   logic [31:0] wdata[2], rdata[2], dina[2], douta[2], rd1[2], rd2[2];
   logic [31:0] ram_mem[2][64];
   logic [31:0] mdl_mem[2][64];
   logic [31:0] mdl_rd[2];
   int checks = 0;
   int errors = 0;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      ram_b_lsu #(.ADDR_W(6), .RAM_LAT(g + 1)) u_dut (
         .clka(clk), .rsta_n(rsta_n), .req(req[g]), .we(we[g]), .size(size[g]),
         .sign_ext(sext[g]), .addr(addr[g]), .wdata(wdata[g]), .busy(busy[g]),
         .done(done[g]), .err(err[g]), .rdata(rdata[g]), .ram_wea(wea[g]),
         .ram_addra(addra[g]), .ram_dina(dina[g]), .ram_douta(douta[g]));
   end

   // RAM_B models: read-first, one or two output register stages.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (wea[k]) ram_mem[k][addra[k]] <= dina[k];
         rd1[k] <= ram_mem[k][addra[k]];
         rd2[k] <= rd1[k];
      end
   end
   assign douta[0] = rd1[0];
   assign douta[1] = rd2[1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: results computed directly from the lane/extension/latency rules.
   task automatic model_op(input int k, input logic w, input logic [1:0] sz, input logic sx,
                           input logic [7:0] a, input logic [31:0] d, output logic e,
                           output int lat, output int wn, output logic [31:0] rd);
      int sh, idx;
      logic [31:0] m, v;
      bit legal;
      sh  = int'(a[1:0]) * 8;
      idx = int'(a[7:2]);
      legal = (sz == 2'd0) || (sz == 2'd1 && a[0] == 1'b0) || (sz == 2'd2 && a[1:0] == 2'd0);
      m = (sz == 2'd0) ? 32'h0000_00FF : (sz == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      e = 1'b0; wn = 0; rd = mdl_rd[k];
      if (!legal) begin
         e = 1'b1; lat = 1;
      end else if (w) begin
         mdl_mem[k][idx] = (mdl_mem[k][idx] & ~(m << sh)) | ((d & m) << sh);
         lat = (sz == 2'd2) ? 2 : 3 + (k + 1);
         wn = 1;
      end else begin
         v = (mdl_mem[k][idx] >> sh) & m;
         if (sx && ((v & ((m >> 1) + 32'd1)) != 32'd0)) v = v | ~m;
         mdl_rd[k] = v; rd = v;
         lat = 2 + (k + 1);
      end
   endtask

   task automatic run_op(input int k, input logic w, input logic [1:0] sz, input logic sx,
                         input logic [7:0] a, input logic [31:0] d, input bit storm,
                         output int lat, output int wn, output logic e, output int nd);
      @(negedge clk);
      req[k] = 1'b1; we[k] = w; size[k] = sz; sext[k] = sx; addr[k] = a; wdata[k] = d;
      @(posedge clk); #1;
      req[k] = 1'b0;
      lat = 0; nd = 0; e = 1'b0;
      wn = wea[k] ? 1 : 0;
      for (int c = 1; c <= 25; c++) begin
         if (storm && busy[k]) begin
            req[k] = 1'b1; addr[k] = 8'($urandom);
         end else begin
            req[k] = 1'b0;
         end
         @(posedge clk); #1;
         if (wea[k]) wn++;
         if (done[k]) begin
            nd++;
            if (lat == 0) begin lat = c; e = err[k]; end
         end
         if (lat != 0 && c >= lat + (storm ? 8 : 0)) break;
      end
      req[k] = 1'b0;
   endtask

   task automatic compare_op(input int k, input string tag, input logic w, input logic [1:0] sz,
                             input logic sx, input logic [7:0] a, input logic [31:0] d);
      int lat, wn, nd, xlat, xwn;
      logic e, xe;
      logic [31:0] xrd;
      model_op(k, w, sz, sx, a, d, xe, xlat, xwn, xrd);
      run_op(k, w, sz, sx, a, d, 1'b0, lat, wn, e, nd);
      check($sformatf("%s_err", tag), 32'(e), 32'(xe));
      check($sformatf("%s_lat", tag), lat, xlat);
      check($sformatf("%s_wea", tag), wn, xwn);
      check($sformatf("%s_rdata", tag), rdata[k], xrd);
      if (w && !xe) check($sformatf("%s_mem", tag), ram_mem[k][a[7:2]], mdl_mem[k][a[7:2]]);
   endtask

   typedef struct {
      logic        w;
      logic [1:0]  sz;
      logic        sx;
      logic [7:0]  a;
      logic [31:0] d;
      logic        xe;
      int          lat1;
      bit          scale;
      int          xwn;
      bit          keep;
      logic [31:0] xrd;
   } vec_t;

   vec_t vecs[14];

   initial begin
      int lat, wn, nd, xlat, xwn;
      logic e, xe;
      logic [31:0] xrd, prev;

      vecs[0]  = '{1'b1, 2'd2, 1'b0, 8'h08, 32'h80F0_0607, 1'b0, 2, 1'b0, 1, 1'b1, 32'h0};
      vecs[1]  = '{1'b0, 2'd0, 1'b1, 8'h0B, 32'h0,         1'b0, 3, 1'b1, 0, 1'b0, 32'hFFFF_FF80};
      vecs[2]  = '{1'b0, 2'd0, 1'b0, 8'h0B, 32'h0,         1'b0, 3, 1'b1, 0, 1'b0, 32'h0000_0080};
      vecs[3]  = '{1'b0, 2'd1, 1'b1, 8'h0A, 32'h0,         1'b0, 3, 1'b1, 0, 1'b0, 32'hFFFF_80F0};
      vecs[4]  = '{1'b0, 2'd2, 1'b0, 8'h08, 32'h0,         1'b0, 3, 1'b1, 0, 1'b0, 32'h80F0_0607};
      vecs[5]  = '{1'b1, 2'd2, 1'b0, 8'h0C, 32'h0000_0003, 1'b0, 2, 1'b0, 1, 1'b1, 32'h0};
      vecs[6]  = '{1'b1, 2'd0, 1'b0, 8'h0D, 32'h0000_00AB, 1'b0, 4, 1'b1, 1, 1'b1, 32'h0};
      vecs[7]  = '{1'b0, 2'd2, 1'b0, 8'h0C, 32'h0,         1'b0, 3, 1'b1, 0, 1'b0, 32'h0000_AB03};
      vecs[8]  = '{1'b0, 2'd1, 1'b0, 8'h01, 32'h0,         1'b1, 1, 1'b0, 0, 1'b1, 32'h0};
      vecs[9]  = '{1'b1, 2'd2, 1'b0, 8'h06, 32'h1234_5678, 1'b1, 1, 1'b0, 0, 1'b1, 32'h0};
      vecs[10] = '{1'b0, 2'd3, 1'b0, 8'h00, 32'h0,         1'b1, 1, 1'b0, 0, 1'b1, 32'h0};
      vecs[11] = '{1'b1, 2'd1, 1'b0, 8'h0E, 32'h5555_CDEF, 1'b0, 4, 1'b1, 1, 1'b1, 32'h0};
      vecs[12] = '{1'b0, 2'd1, 1'b0, 8'h0E, 32'h0,         1'b0, 3, 1'b1, 0, 1'b0, 32'h0000_CDEF};
      vecs[13] = '{1'b0, 2'd0, 1'b1, 8'h0C, 32'h0,         1'b0, 3, 1'b1, 0, 1'b0, 32'h0000_0003};

      for (int k = 0; k < 2; k++) begin
         req[k] = 1'b0; we[k] = 1'b0; size[k] = 2'd0; sext[k] = 1'b0;
         addr[k] = 8'h00; wdata[k] = 32'h0; mdl_rd[k] = 32'h0;
      end
      rsta_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rst%0d_busy", k), 32'(busy[k]), 32'h0);
         check($sformatf("rst%0d_done", k), 32'(done[k]), 32'h0);
         check($sformatf("rst%0d_err", k), 32'(err[k]), 32'h0);
         check($sformatf("rst%0d_wea", k), 32'(wea[k]), 32'h0);
         check($sformatf("rst%0d_rdata", k), rdata[k], 32'h0);
         check($sformatf("rst%0d_addra", k), 32'(addra[k]), 32'h0);
         check($sformatf("rst%0d_dina", k), dina[k], 32'h0);
      end
      @(negedge clk);
      rsta_n = 1'b1;

      // Word store to word 1 on the RAM_LAT=1 instance.
      model_op(0, 1'b1, 2'd2, 1'b0, 8'h04, 32'hFFFF_FFFF, xe, xlat, xwn, xrd);
      run_op(0, 1'b1, 2'd2, 1'b0, 8'h04, 32'hFFFF_FFFF, 1'b0, lat, wn, e, nd);
      check("wst_lat", lat, 2);
      check("wst_wea", wn, 1);
      check("wst_addra", 32'(addra[0]), 32'd1);
      check("wst_mem", ram_mem[0][1], 32'hFFFF_FFFF);

      // Byte store aborted by reset while waiting for the read.
      @(negedge clk);
      req[0] = 1'b1; we[0] = 1'b1; size[0] = 2'd0; addr[0] = 8'h05; wdata[0] = 32'h0000_0011;
      @(posedge clk); #1;
      req[0] = 1'b0;
      check("abort_busy", 32'(busy[0]), 32'h1);
      @(posedge clk); #1;
      rsta_n = 1'b0;
      #1;
      check("abort_wea", 32'(wea[0]), 32'h0);
      check("abort_busy_rst", 32'(busy[0]), 32'h0);
      mdl_rd[0] = 32'h0; mdl_rd[1] = 32'h0;
      @(negedge clk);
      @(negedge clk);
      rsta_n = 1'b1;
      nd = 0; wn = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done[0]) nd++;
         if (wea[0]) wn++;
      end
      check("abort_done", nd, 0);
      check("abort_wea_cnt", wn, 0);
      check("abort_mem", ram_mem[0][1], 32'hFFFF_FFFF);
      compare_op(0, "abort_reload", 1'b0, 2'd2, 1'b0, 8'h04, 32'h0);

      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 14; i++) begin
            prev = rdata[k];
            model_op(k, vecs[i].w, vecs[i].sz, vecs[i].sx, vecs[i].a, vecs[i].d, xe, xlat, xwn, xrd);
            run_op(k, vecs[i].w, vecs[i].sz, vecs[i].sx, vecs[i].a, vecs[i].d, 1'b0, lat, wn, e, nd);
            check($sformatf("vec%0d_%0d_err", k, i), 32'(e), 32'(vecs[i].xe));
            check($sformatf("vec%0d_%0d_lat", k, i), lat, vecs[i].lat1 + (vecs[i].scale ? k : 0));
            check($sformatf("vec%0d_%0d_wea", k, i), wn, vecs[i].xwn);
            check($sformatf("vec%0d_%0d_rdata", k, i), rdata[k], vecs[i].keep ? prev : vecs[i].xrd);
         end
         check($sformatf("vec%0d_word3", k), ram_mem[k][3], 32'hCDEF_AB03);

         // Requests hammered while busy must be dropped.
         model_op(k, 1'b0, 2'd2, 1'b0, 8'h08, 32'h0, xe, xlat, xwn, xrd);
         run_op(k, 1'b0, 2'd2, 1'b0, 8'h08, 32'h0, 1'b1, lat, wn, e, nd);
         check($sformatf("storm%0d_ndone", k), nd, 1);
         check($sformatf("storm%0d_lat", k), lat, xlat);
         check($sformatf("storm%0d_rdata", k), rdata[k], 32'h80F0_0607);
         check($sformatf("storm%0d_wea", k), wn, 0);

         for (int i = 0; i < 64; i++)
            compare_op(k, $sformatf("init%0d_%0d", k, i), 1'b1, 2'd2, 1'b0, 8'(i * 4), $urandom);
         for (int i = 0; i < 80; i++)
            compare_op(k, $sformatf("rnd%0d_%0d", k, i), 1'($urandom), 2'($urandom),
                       1'($urandom), 8'($urandom), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
